// File: rtl/julia_param_pkg.sv
// Shared constants for the Julia-set parameter bank: CTRL/STATUS bit layout and
// the register offsets derived from the channel count.
package julia_param_pkg;

   localparam int unsigned CTRL_COMMIT    = 0;
   localparam int unsigned CTRL_IMMEDIATE = 1;

   localparam int unsigned STATUS_PENDING = 0;
   localparam int unsigned STATUS_CNT_LSB = 8;
   localparam int unsigned STATUS_CNT_W   = 8;

   function automatic int unsigned ctrl_offset(int unsigned num_ch);
      return num_ch;
   endfunction

   function automatic int unsigned status_offset(int unsigned num_ch);
      return num_ch + 1;
   endfunction

endpackage

// File: rtl/julia_param_chan.sv
// One parameter channel: software-visible shadow register plus the active copy
// that feeds the pixel engines. Apply copies shadow as registered this cycle.
module julia_param_chan #(
   parameter int unsigned DATA_W = 27
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              we,
   input  logic [DATA_W-1:0] wdata,
   input  logic              apply,
   output logic [DATA_W-1:0] shadow,
   output logic [DATA_W-1:0] active
);

   logic [DATA_W-1:0] shadow_q;
   logic [DATA_W-1:0] active_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         shadow_q <= '0;
         active_q <= '0;
      end else begin
         if (we) shadow_q <= wdata;
         if (apply) active_q <= shadow_q;
      end
   end

   assign shadow = shadow_q;
   assign active = active_q;

endmodule

// File: rtl/julia_param_bank.sv
// Double-buffered Avalon-MM parameter bank: shadow writes, then a commit swaps
// all channels to the active set either immediately or at the next frame start.
module julia_param_bank
   import julia_param_pkg::*;
#(
   parameter int unsigned NUM_CH = 4,
   parameter int unsigned DATA_W = 27,
   parameter int unsigned ADDR_W = 3
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic [ADDR_W-1:0]        avs_address,
   input  logic                     avs_write,
   input  logic [31:0]              avs_writedata,
   input  logic                     avs_read,
   output logic [31:0]              avs_readdata,
   input  logic                     frame_start,
   output logic [NUM_CH*DATA_W-1:0] param_out,
   output logic                     param_valid,
   output logic                     commit_pending
);

   localparam logic [ADDR_W-1:0] CtrlAddr   = ADDR_W'(ctrl_offset(NUM_CH));
   localparam logic [ADDR_W-1:0] StatusAddr = ADDR_W'(status_offset(NUM_CH));

   logic [DATA_W-1:0] shadow [NUM_CH];
   logic [DATA_W-1:0] active [NUM_CH];

   logic                    ctrl_wr;
   logic                    commit_req;
   logic                    imm_d;
   logic                    pending_d;
   logic                    apply;
   logic                    imm_q;
   logic                    pending_q;
   logic                    valid_q;
   logic [STATUS_CNT_W-1:0] cnt_q;
   logic [31:0]             rdata_d;
   logic [31:0]             rdata_q;
   logic                    unused_wdata;

   assign unused_wdata = ^avs_writedata;

   // COMMIT is judged against the IMMEDIATE value written in the same access.
   always_comb begin
      ctrl_wr    = avs_write && (avs_address == CtrlAddr);
      imm_d      = ctrl_wr ? avs_writedata[CTRL_IMMEDIATE] : imm_q;
      commit_req = ctrl_wr && avs_writedata[CTRL_COMMIT];
      apply      = (commit_req && imm_d) || (pending_q && frame_start);
      pending_d  = pending_q;
      if (apply) begin
         pending_d = 1'b0;
      end else if (commit_req) begin
         pending_d = 1'b1;
      end
   end

   for (genvar k = 0; k < NUM_CH; k++) begin : g_chan
      julia_param_chan #(
         .DATA_W (DATA_W)
      ) u_chan (
         .clk     (clk),
         .reset_n (reset_n),
         .we      (avs_write && (avs_address == ADDR_W'(k))),
         .wdata   (avs_writedata[DATA_W-1:0]),
         .apply   (apply),
         .shadow  (shadow[k]),
         .active  (active[k])
      );
      assign param_out[k*DATA_W +: DATA_W] = active[k];
   end

   always_comb begin
      rdata_d = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (avs_address == ADDR_W'(k)) rdata_d = 32'(shadow[k]);
      end
      if (avs_address == CtrlAddr) begin
         rdata_d[CTRL_IMMEDIATE] = imm_q;
      end
      if (avs_address == StatusAddr) begin
         rdata_d[STATUS_PENDING]                   = pending_q;
         rdata_d[STATUS_CNT_LSB +: STATUS_CNT_W]   = cnt_q;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         imm_q     <= 1'b0;
         pending_q <= 1'b0;
         valid_q   <= 1'b0;
         cnt_q     <= '0;
         rdata_q   <= '0;
      end else begin
         imm_q     <= imm_d;
         pending_q <= pending_d;
         valid_q   <= apply;
         if (apply) cnt_q <= cnt_q + 1'b1;
         if (avs_read) rdata_q <= rdata_d;
      end
   end

   assign avs_readdata   = rdata_q;
   assign param_valid    = valid_q;
   assign commit_pending = pending_q;

endmodule

// File: tb/tb_julia_param_bank.sv
// Scoreboard bench for julia_param_bank: stimulus queues expected read data and
// expected active sets; a negedge monitor pops and compares as the DUT responds.
module tb_julia_param_bank;

   localparam int unsigned NUM_CH = 4;
   localparam int unsigned DATA_W = 27;
   localparam int unsigned ADDR_W = 3;
   localparam int unsigned PW     = NUM_CH * DATA_W;

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic [ADDR_W-1:0] avs_address = '0;
   logic              avs_write = 1'b0;
   logic [31:0]       avs_writedata = '0;
   logic              avs_read = 1'b0;
   logic [31:0]       avs_readdata;
   logic              frame_start = 1'b0;
   logic [PW-1:0]     param_out;
   logic              param_valid;
   logic              commit_pending;

   int checks = 0;
   int errors = 0;

   logic [31:0]   exp_rd [$];
   logic [PW-1:0] exp_po [$];
   logic          rd_seen = 1'b0;

   julia_param_bank #(
      .NUM_CH (NUM_CH),
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .avs_address    (avs_address),
      .avs_write      (avs_write),
      .avs_writedata  (avs_writedata),
      .avs_read       (avs_read),
      .avs_readdata   (avs_readdata),
      .frame_start    (frame_start),
      .param_out      (param_out),
      .param_valid    (param_valid),
      .commit_pending (commit_pending)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic logic [PW-1:0] pack(input logic [DATA_W-1:0] c3, input logic [DATA_W-1:0] c2,
                                          input logic [DATA_W-1:0] c1, input logic [DATA_W-1:0] c0);
      return {c3, c2, c1, c0};
   endfunction

   always @(posedge clk) rd_seen <= avs_read;

   always @(negedge clk) begin
      if (rd_seen) begin
         if (exp_rd.size() == 0) check("unexpected_read", 1, 0);
         else check("readdata", avs_readdata, exp_rd.pop_front());
      end
      if (param_valid) begin
         if (exp_po.size() == 0) check("unexpected_param_valid", 1, 0);
         else check("param_out_on_valid", param_out, exp_po.pop_front());
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input int addr, input logic [31:0] data);
      avs_address   = ADDR_W'(addr);
      avs_writedata = data;
      avs_write     = 1'b1;
      cyc();
      avs_write     = 1'b0;
   endtask

   task automatic rd(input int addr, input logic [31:0] exp);
      avs_address = ADDR_W'(addr);
      avs_read    = 1'b1;
      exp_rd.push_back(exp);
      cyc();
      avs_read    = 1'b0;
   endtask

   task automatic frame();
      frame_start = 1'b1;
      cyc();
      frame_start = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      repeat (3) cyc();
      reset_n = 1'b1;
      cyc();
      check("reset_param_out", param_out, 0);
      check("reset_param_valid", param_valid, 0);
      check("reset_pending", commit_pending, 0);
      check("reset_readdata", avs_readdata, 0);
      for (int a = 0; a < 8; a++) rd(a, 32'h0);

      // Upper write bits are dropped; active set untouched by shadow writes.
      wr(0, 32'hFFFF_FFFF);
      rd(0, 32'h07FF_FFFF);
      check("shadow_write_no_apply", param_out, 0);

      // Frame-synced commit.
      wr(0, 1); wr(1, 2); wr(2, 3); wr(3, 4);
      wr(4, 32'h1);
      check("frame_pending_set", commit_pending, 1);
      check("frame_not_applied", param_out, 0);
      cyc();
      check("frame_still_pending", commit_pending, 1);
      exp_po.push_back(pack(4, 3, 2, 1));
      frame();
      check("frame_applied", param_out, pack(4, 3, 2, 1));
      check("frame_pending_clear", commit_pending, 0);
      cyc();
      rd(5, 32'h0000_0100);

      // Immediate commit.
      wr(2, 32'h155);
      exp_po.push_back(pack(4, 32'h155, 2, 1));
      wr(4, 32'h3);
      check("imm_valid", param_valid, 1);
      check("imm_no_pending", commit_pending, 0);
      rd(5, 32'h0000_0200);
      rd(4, 32'h0000_0002);

      // COMMIT with frame_start in the same cycle waits for the next frame.
      wr(4, 32'h0);
      wr(0, 32'hA);
      avs_address = 3'd4; avs_writedata = 32'h1; avs_write = 1'b1; frame_start = 1'b1;
      cyc();
      avs_write = 1'b0; frame_start = 1'b0;
      check("same_cycle_pending", commit_pending, 1);
      check("same_cycle_no_apply", param_out, pack(4, 32'h155, 2, 1));
      cyc();
      exp_po.push_back(pack(4, 32'h155, 2, 32'hA));
      frame();

      // Shadow write during the apply cycle: active takes the old value.
      wr(4, 32'h1);
      exp_po.push_back(pack(4, 32'h155, 2, 32'hA));
      avs_address = 3'd1; avs_writedata = 32'h77; avs_write = 1'b1; frame_start = 1'b1;
      cyc();
      avs_write = 1'b0; frame_start = 1'b0;
      rd(1, 32'h77);
      rd(5, 32'h0000_0400);

      // IMMEDIATE=1 while pending keeps the commit pending until frame_start.
      wr(4, 32'h1);
      wr(4, 32'h2);
      cyc();
      check("imm_set_keeps_pending", commit_pending, 1);
      check("imm_set_no_apply", param_out, pack(4, 32'h155, 2, 32'hA));
      exp_po.push_back(pack(4, 32'h155, 32'h77, 32'hA));
      frame();
      check("pending_applied_on_frame", commit_pending, 0);
      rd(5, 32'h0000_0500);

      // Reset while pending: pending cleared, later frame_start does nothing.
      wr(4, 32'h1);
      check("pre_reset_pending", commit_pending, 1);
      reset_n = 1'b0;
      #2;
      check("async_reset_pending", commit_pending, 0);
      check("async_reset_param_out", param_out, 0);
      cyc();
      reset_n = 1'b1;
      cyc();
      frame();
      cyc();
      check("post_reset_no_apply", param_out, 0);
      rd(5, 32'h0);
      rd(4, 32'h0);

      // COMMIT_CNT wrap.
      for (int i = 0; i < 255; i++) begin
         exp_po.push_back('0);
         wr(4, 32'h3);
      end
      rd(5, 32'h0000_FF00);
      exp_po.push_back('0);
      wr(4, 32'h3);
      rd(5, 32'h0000_0000);

      repeat (3) cyc();
      check("param_queue_drained", exp_po.size(), 0);
      check("read_queue_drained", exp_rd.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
